ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 command transmitter that drives the
//                shared PS2_CLK/PS2_DAT pins as open-drain pull-downs.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_CYCLES     = 100,
    parameter int FRAME_TIMEOUT  = 1000000
) (
    input  logic       clock50,
    input  logic       resetN,
    input  logic       txStart,
    input  logic [7:0] txData,
    input  logic       keyboardClock,
    input  logic       keyboardData,
    output logic       keyboardClockOe,
    output logic       keyboardDataOe,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError
);

    localparam int MAX_IR  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAX_CNT = (MAX_IR > FRAME_TIMEOUT) ? MAX_IR : FRAME_TIMEOUT;
    localparam int TMR_W   = $clog2(MAX_CNT + 1);

    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] REQ_LAST = TMR_W'(REQ_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(FRAME_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    logic [2:0]       state_q,   state_d;
    logic [8:0]       shift_q,   shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic             err_q,     err_d;
    logic             dat_oe_q,  dat_oe_d;

    logic clk_s1_q, clk_s2_q, clk_dly_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_edge;
    logic timeout_hit;

    // Idle-high reset values keep a released bus from looking like a falling edge.
    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_dly_q <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
        end else begin
            clk_s1_q  <= keyboardClock;
            clk_s2_q  <= clk_s1_q;
            clk_dly_q <= clk_s2_q;
            dat_s1_q  <= keyboardData;
            dat_s2_q  <= dat_s1_q;
        end
    end

    assign fall_edge   = clk_dly_q & ~clk_s2_q;
    assign timeout_hit = (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE)
                         && (timer_q == TMO_LAST);

    always_ff @(posedge clock50 or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        err_d     = err_q;
        dat_oe_d  = dat_oe_q;

        unique case (state_q)
            ST_IDLE: begin
                if (txStart) begin
                    state_d   = ST_INHIBIT;
                    shift_d   = {~^txData, txData};
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    err_d     = 1'b0;
                    dat_oe_d  = 1'b0;
                end
            end
            ST_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    state_d = ST_REQ;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (timer_q == REQ_LAST) begin
                    state_d  = ST_SEND;
                    timer_d  = '0;
                    dat_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SEND: begin
                timer_d = timer_q + 1'b1;
                if (timeout_hit) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b1;
                    dat_oe_d = 1'b0;
                end else if (fall_edge) begin
                    // Ones shift in from the top, so the tenth edge drives the stop bit (released).
                    dat_oe_d  = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                timer_d = timer_q + 1'b1;
                if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (fall_edge) begin
                    err_d   = dat_s2_q;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                timer_d = timer_q + 1'b1;
                if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (clk_s2_q && dat_s2_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                dat_oe_d = 1'b0;
            end
        endcase
    end

    // Outputs decode straight from state so an async reset frees the pins at once.
    always_comb begin
        keyboardClockOe = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
        keyboardDataOe  = (state_q == ST_REQ) || ((state_q == ST_SEND) && dat_oe_q);
        txBusy          = (state_q != ST_IDLE);
        txDone          = (state_q == ST_DONE);
        txError         = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int REQ  = 8;
    localparam int TMO  = 1500;
    localparam int HALF = 15;

    logic       clock50 = 1'b0;
    logic       resetN  = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txData  = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       keyboardClock, keyboardData;
    logic       keyboardClockOe, keyboardDataOe, txBusy, txDone, txError;

    int n_total = 0;
    int n_bad   = 0;

    // Wired-AND open-drain bus with pull-ups.
    assign keyboardClock = dev_clk & ~keyboardClockOe;
    assign keyboardData  = dev_dat & ~keyboardDataOe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .FRAME_TIMEOUT (TMO)
    ) dut (
        .clock50        (clock50),
        .resetN         (resetN),
        .txStart        (txStart),
        .txData         (txData),
        .keyboardClock  (keyboardClock),
        .keyboardData   (keyboardData),
        .keyboardClockOe(keyboardClockOe),
        .keyboardDataOe (keyboardDataOe),
        .txBusy         (txBusy),
        .txDone         (txDone),
        .txError        (txError)
    );

    always #5 clock50 = ~clock50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line levels a device sees: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (($countones(d) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clock50);
        txStart = 1'b1;
        txData  = d;
        @(negedge clock50);
        txStart = 1'b0;
        txData  = 8'($urandom);
        check("busy_after_start", txBusy, 1);
        check("err_cleared", txError, 0);
    endtask

    task automatic measure_phases(input string tag);
        int n;
        n = 0;
        while (keyboardClockOe && !keyboardDataOe && n < INH + 50) begin
            @(negedge clock50);
            n++;
        end
        check({tag, "_inhibit_len"}, n, INH);
        n = 0;
        while (keyboardClockOe && keyboardDataOe && n < REQ + 50) begin
            @(negedge clock50);
            n++;
        end
        check({tag, "_req_len"}, n, REQ);
        check({tag, "_send_lines"}, {keyboardClockOe, keyboardDataOe}, 2'b01);
    endtask

    // Device: waits for request-to-send, clocks 11 edges, reads data while clock is low.
    task automatic device_frame(input bit nack, input int stop_at, input bit poke,
                                input logic [7:0] other, output logic [10:0] bits, output bit ok);
        int n;
        n    = 0;
        bits = '0;
        while (!(keyboardClock && !keyboardData) && n < 200) begin
            @(negedge clock50);
            n++;
        end
        ok      = (n < 200);
        bits[0] = keyboardData;
        for (int e = 1; e <= 11; e++) begin
            repeat (HALF) @(negedge clock50);
            dev_clk = 1'b0;
            if (e == stop_at) return;
            for (int k = 0; k < HALF; k++) begin
                if (poke && e == 3 && k == 1) begin
                    txStart = 1'b1;
                    txData  = other;
                end else begin
                    txStart = 1'b0;
                end
                @(negedge clock50);
            end
            if (e <= 10) bits[e] = keyboardData;
            dev_clk = 1'b1;
            if (e == 10 && !nack) dev_dat = 1'b0;
            if (e == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (!txDone && n < TMO + 100) begin
            @(negedge clock50);
            n++;
        end
        check({tag, "_done_seen"}, txDone, 1);
        check({tag, "_busy_in_done"}, txBusy, 1);
        check({tag, "_error"}, txError, exp_err);
        @(negedge clock50);
        check({tag, "_idle_after"}, {txBusy, txDone, keyboardClockOe, keyboardDataOe}, 4'b0);
        check({tag, "_err_held"}, txError, exp_err);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit nack,
                             input bit poke, input logic [7:0] other, output logic [10:0] bits);
        bit ok;
        start_tx(d);
        measure_phases(tag);
        device_frame(nack, 0, poke, other, bits, ok);
        check({tag, "_rts_seen"}, ok, 1);
        check({tag, "_bits"}, bits, frame_bits(d));
        wait_done(tag, nack);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        logic [7:0]  d;
        bit          ok;
        int          n;

        repeat (3) @(negedge clock50);
        check("reset_outputs", {keyboardClockOe, keyboardDataOe, txBusy, txDone, txError}, 5'b0);
        resetN = 1'b1;
        repeat (3) @(negedge clock50);

        // Device clock edges while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            dev_clk = 1'b0;
            repeat (6) @(negedge clock50);
            dev_clk = 1'b1;
            repeat (6) @(negedge clock50);
        end
        check("idle_edges_ignored", {txBusy, keyboardClockOe, keyboardDataOe}, 3'b0);

        run_frame("ed", 8'hED, 1'b0, 1'b0, 8'h00, bits);
        check("ed_literal", bits, 11'b11_1110_1101_0);
        run_frame("zero", 8'h00, 1'b0, 1'b0, 8'h00, bits);
        check("zero_parity", bits[9], 1);
        run_frame("one", 8'h01, 1'b0, 1'b0, 8'h00, bits);
        check("one_parity", bits[9], 0);
        run_frame("nack", 8'h3C, 1'b1, 1'b0, 8'h00, bits);
        run_frame("poke", 8'h55, 1'b0, 1'b1, 8'hAA, bits);

        // No device clock after the request: frame timeout.
        start_tx(8'h5A);
        measure_phases("tmo");
        n = 0;
        while (!txDone && n < TMO + 50) begin
            @(negedge clock50);
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_error", txError, 1);
        @(negedge clock50);
        check("tmo_released", {txBusy, keyboardClockOe, keyboardDataOe}, 3'b0);

        // Asynchronous reset while the device is on edge 5.
        start_tx(8'hA5);
        measure_phases("rst");
        device_frame(1'b0, 5, 1'b0, 8'h00, bits, ok);
        check("rst_rts_seen", ok, 1);
        @(negedge clock50);
        check("rst_pre_datoe", keyboardDataOe, 1);
        #3 resetN = 1'b0;
        #1;
        check("rst_async_outputs",
              {keyboardClockOe, keyboardDataOe, txBusy, txDone, txError}, 5'b0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge clock50);
        resetN = 1'b1;
        repeat (2) @(negedge clock50);
        run_frame("post_rst", 8'hC3, 1'b0, 1'b0, 8'h00, bits);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            run_frame("rand", d, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ~d, bits);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
